mem_responder: RTL and testbench

// - Bus responder that answers the CPU's mem_cmd/mem_addr/write_data requests and returns read_data.
// - Decodes the bus into three targets: 256x16 program/data RAM, an LED output register and a synchronised switch input.
// - Contains a boot loader port. After reset it holds the CPU in reset and fills RAM over a valid/ready handshake.
// - Sits between cpu and the board I/O at the top level.

---
 rtl/mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Purpose: CPU bus responder decoding a 256x16 RAM, an LED register and synchronised switches, with a boot loader.
// Latency: reads return registered data one edge after the command; switch changes reach reads after a 2-flop sync.
// Backpressure: none on the CPU bus; the loader is accepted only while in LOAD (ld_ready high), one word per cycle.
module mem_responder #(
  parameter int         RAM_AW    = 8,
  parameter logic [8:0] LED_ADDR  = 9'h100,
  parameter logic [8:0] SW_ADDR   = 9'h140,
  parameter bit         BOOT_LOAD = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  input  logic [7:0]  sw_in,
  output logic [7:0]  led_out,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic        ld_done,
  output logic        cpu_reset,
  output logic        bus_err,
  output logic [7:0]  err_count
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_ILL   = 2'b11;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // Decoded view of the current bus command, already qualified by RUN.
  typedef struct packed {
    logic rd;
    logic wr;
    logic ill;
    logic ram;
    logic led;
    logic sw;
  } req_t;

  state_t            state;
  req_t              req;
  logic              run;
  logic              err_next;
  logic [15:0]       rd_mux;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_wa;
  logic [15:0]       ram_wd;
  logic [7:0]        sw_meta;
  logic [7:0]        sw_sync;
  logic [15:0]       mem [RAM_DEPTH];

  assign run = (state == ST_RUN);

  // Decode the CPU command and address; outside RUN every command reads as idle.
  always_comb begin
    req     = '0;
    req.rd  = run && (mem_cmd == CMD_READ);
    req.wr  = run && (mem_cmd == CMD_WRITE);
    req.ill = run && (mem_cmd == CMD_ILL);
    req.ram = ~mem_addr[8];
    req.led = (mem_addr == LED_ADDR);
    req.sw  = (mem_addr == SW_ADDR);
  end

  // Illegal command, unmapped read, or a write to read-only/unmapped space is an error.
  always_comb begin
    err_next = req.ill
             | (req.rd & ~(req.ram | req.led | req.sw))
             | (req.wr & ~(req.ram | req.led));
  end

  // Read data source selection; unmapped addresses return zero.
  always_comb begin
    rd_mux = 16'h0000;
    if (req.ram) begin
      rd_mux = mem[mem_addr[RAM_AW-1:0]];
    end else if (req.led) begin
      rd_mux = {8'h00, led_out};
    end else if (req.sw) begin
      rd_mux = {8'h00, sw_sync};
    end
  end

  // Single RAM write port shared by the loader (LOAD only) and the CPU (RUN only).
  always_comb begin
    ram_we = 1'b0;
    ram_wa = '0;
    ram_wd = 16'h0000;
    if (!reset) begin
      if (state == ST_LOAD && ld_valid) begin
        ram_we = 1'b1;
        ram_wa = ld_addr[RAM_AW-1:0];
        ram_wd = ld_data;
      end else if (req.wr && req.ram) begin
        ram_we = 1'b1;
        ram_wa = mem_addr[RAM_AW-1:0];
        ram_wd = write_data;
      end
    end
  end

  // RAM array; contents deliberately survive reset so a reset mid-load keeps written words.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_wa] <= ram_wd;
    end
  end

  // Boot sequencing: LOAD holds the CPU in reset, RELEASE adds one guard cycle, RUN serves the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BOOT_LOAD ? ST_LOAD : ST_RUN;
      cpu_reset <= BOOT_LOAD;
      ld_ready  <= BOOT_LOAD;
    end else begin
      case (state)
        ST_LOAD: begin
          if (ld_done) begin
            state     <= ST_RELEASE;
            cpu_reset <= 1'b1;
            ld_ready  <= 1'b0;
          end else begin
            cpu_reset <= 1'b1;
            ld_ready  <= 1'b1;
          end
        end
        ST_RELEASE: begin
          state     <= ST_RUN;
          cpu_reset <= 1'b0;
          ld_ready  <= 1'b0;
        end
        ST_RUN: begin
          cpu_reset <= 1'b0;
          ld_ready  <= 1'b0;
        end
        default: begin
          state     <= ST_RUN;
          cpu_reset <= 1'b0;
          ld_ready  <= 1'b0;
        end
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous board switches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= 8'h00;
      sw_sync <= 8'h00;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  // Registered read data; idle, write and illegal commands leave it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= 16'h0000;
    end else if (req.rd) begin
      read_data <= rd_mux;
    end
  end

  // LED register, written only by a RUN-state write to its address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= 8'h00;
    end else if (req.wr && req.led) begin
      led_out <= write_data[7:0];
    end
  end

  // Error pulse for the cycle after the offending edge, plus a saturating tally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err   <= 1'b0;
      err_count <= 8'h00;
    end else begin
      bus_err <= err_next;
      if (err_next && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  // Unused command encoding kept named for readability of the decode above.
  logic unused_idle;
  assign unused_idle = (CMD_IDLE == 2'b00);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: boot load, table-driven bus vectors, switch sync,
// loader-in-RUN, error saturation and reset during load. A BOOT_LOAD=0 instance checks direct-run reset.
module tb_mem_responder;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;
  localparam logic [1:0] IL = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mem_cmd = ID;
  logic [8:0]  mem_addr = '0;
  logic [15:0] write_data = '0;
  logic [15:0] read_data;
  logic [7:0]  sw_in = '0;
  logic [7:0]  led_out;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [7:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        ld_done = 1'b0;
  logic        cpu_reset;
  logic        bus_err;
  logic [7:0]  err_count;

  // Second instance, BOOT_LOAD=0, with a quiet bus.
  logic [15:0] read_data0;
  logic [7:0]  led_out0;
  logic        ld_ready0;
  logic        cpu_reset0;
  logic        bus_err0;
  logic [7:0]  err_count0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.BOOT_LOAD(1'b1)) dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(read_data), .sw_in(sw_in), .led_out(led_out),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_done(ld_done), .cpu_reset(cpu_reset), .bus_err(bus_err), .err_count(err_count)
  );

  mem_responder #(.BOOT_LOAD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .mem_cmd(2'b00), .mem_addr(9'h000),
    .write_data(16'h0000), .read_data(read_data0), .sw_in(8'h00), .led_out(led_out0),
    .ld_valid(1'b0), .ld_ready(ld_ready0), .ld_addr(8'h00), .ld_data(16'h0000),
    .ld_done(1'b0), .cpu_reset(cpu_reset0), .bus_err(bus_err0), .err_count(err_count0)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] e_rd;
    logic [7:0]  e_led;
    logic        e_err;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    mem_cmd = c;
    mem_addr = a;
    write_data = d;
    step();
  endtask

  initial begin
    vecs[0]  = '{RD, 9'h001, 16'h0000, 16'hE000, 8'h00, 1'b0, 8'd0};
    vecs[1]  = '{RD, 9'h002, 16'h0000, 16'h1234, 8'h00, 1'b0, 8'd0};
    vecs[2]  = '{RD, 9'h000, 16'h0000, 16'hD105, 8'h00, 1'b0, 8'd0};
    vecs[3]  = '{WR, 9'h03F, 16'hBEEF, 16'hD105, 8'h00, 1'b0, 8'd0};
    vecs[4]  = '{RD, 9'h03F, 16'h0000, 16'hBEEF, 8'h00, 1'b0, 8'd0};
    vecs[5]  = '{ID, 9'h03F, 16'h0000, 16'hBEEF, 8'h00, 1'b0, 8'd0};
    vecs[6]  = '{ID, 9'h000, 16'h0000, 16'hBEEF, 8'h00, 1'b0, 8'd0};
    vecs[7]  = '{WR, 9'h100, 16'h12A5, 16'hBEEF, 8'hA5, 1'b0, 8'd0};
    vecs[8]  = '{RD, 9'h100, 16'h0000, 16'h00A5, 8'hA5, 1'b0, 8'd0};
    vecs[9]  = '{RD, 9'h1FF, 16'h0000, 16'h0000, 8'hA5, 1'b1, 8'd1};
    vecs[10] = '{ID, 9'h000, 16'h0000, 16'h0000, 8'hA5, 1'b0, 8'd1};
    vecs[11] = '{WR, 9'h140, 16'hFFFF, 16'h0000, 8'hA5, 1'b1, 8'd2};
    vecs[12] = '{RD, 9'h140, 16'h0000, 16'h0000, 8'hA5, 1'b0, 8'd2};
    vecs[13] = '{IL, 9'h000, 16'h5555, 16'h0000, 8'hA5, 1'b1, 8'd3};
    vecs[14] = '{RD, 9'h120, 16'h0000, 16'h0000, 8'hA5, 1'b1, 8'd4};
    vecs[15] = '{ID, 9'h000, 16'h0000, 16'h0000, 8'hA5, 1'b0, 8'd4};
    vecs[16] = '{WR, 9'h0FF, 16'hA5A5, 16'h0000, 8'hA5, 1'b0, 8'd4};
    vecs[17] = '{RD, 9'h0FF, 16'h0000, 16'hA5A5, 8'hA5, 1'b0, 8'd4};
    vecs[18] = '{WR, 9'h101, 16'h0077, 16'hA5A5, 8'hA5, 1'b1, 8'd5};
    vecs[19] = '{RD, 9'h100, 16'h0000, 16'h00A5, 8'hA5, 1'b0, 8'd5};
    vecs[20] = '{RD, 9'h000, 16'h0000, 16'hD105, 8'hA5, 1'b0, 8'd5};
    vecs[21] = '{WR, 9'h100, 16'hFF3C, 16'hD105, 8'h3C, 1'b0, 8'd5};

    // Reset state
    repeat (2) step();
    chk("rst.read_data", read_data, 16'h0000);
    chk("rst.led_out", led_out, 8'h00);
    chk("rst.bus_err", bus_err, 1'b0);
    chk("rst.err_count", err_count, 8'h00);
    chk("rst.cpu_reset", cpu_reset, 1'b1);
    chk("rst.ld_ready", ld_ready, 1'b1);
    chk("rst0.cpu_reset", cpu_reset0, 1'b0);
    chk("rst0.ld_ready", ld_ready0, 1'b0);
    reset = 1'b0;

    // Boot load with bus activity that must be ignored
    ld_valid = 1'b1; ld_addr = 8'h00; ld_data = 16'hD105;
    bus(IL, 9'h100, 16'hFFFF);
    chk("load.bus_err", bus_err, 1'b0);
    chk("load.cpu_reset", cpu_reset, 1'b1);
    chk("load.ld_ready", ld_ready, 1'b1);
    ld_addr = 8'h01; ld_data = 16'hE000;
    bus(WR, 9'h100, 16'h00FF);
    chk("load.led_out", led_out, 8'h00);
    chk("load.err_count", err_count, 8'h00);
    ld_addr = 8'h02; ld_data = 16'h1234; ld_done = 1'b1;
    bus(ID, 9'h000, 16'h0000);
    chk("release.cpu_reset", cpu_reset, 1'b1);
    chk("release.ld_ready", ld_ready, 1'b0);
    ld_valid = 1'b0; ld_done = 1'b0;
    step();
    chk("run.cpu_reset", cpu_reset, 1'b0);
    chk("run.ld_ready", ld_ready, 1'b0);
    chk("run.read_data", read_data, 16'h0000);

    // Bus vectors in RUN
    for (int i = 0; i < 22; i++) begin
      bus(vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("v%0d.read_data", i), read_data, vecs[i].e_rd);
      chk($sformatf("v%0d.led_out", i), led_out, vecs[i].e_led);
      chk($sformatf("v%0d.bus_err", i), bus_err, vecs[i].e_err);
      chk($sformatf("v%0d.err_count", i), err_count, vecs[i].e_cnt);
    end

    // Switch synchroniser latency
    sw_in = 8'h3C;
    bus(ID, 9'h000, 16'h0000);
    bus(ID, 9'h000, 16'h0000);
    bus(RD, 9'h140, 16'h0000);
    chk("sw.3c", read_data, 16'h003C);
    sw_in = 8'h5A;
    bus(ID, 9'h000, 16'h0000);
    bus(RD, 9'h140, 16'h0000);
    chk("sw.early", read_data, 16'h003C);
    bus(RD, 9'h140, 16'h0000);
    chk("sw.5a", read_data, 16'h005A);

    // Loader ignored in RUN
    ld_valid = 1'b1; ld_addr = 8'h3F; ld_data = 16'h0000; ld_done = 1'b1;
    bus(ID, 9'h000, 16'h0000);
    chk("runld.ld_ready", ld_ready, 1'b0);
    chk("runld.cpu_reset", cpu_reset, 1'b0);
    ld_valid = 1'b0; ld_done = 1'b0;
    bus(RD, 9'h03F, 16'h0000);
    chk("runld.ram", read_data, 16'hBEEF);

    // Error count saturation: 5 so far plus 300 more
    for (int i = 0; i < 300; i++) begin
      bus(IL, 9'h000, 16'h0000);
    end
    chk("sat.err_count", err_count, 8'hFF);
    chk("sat.bus_err", bus_err, 1'b1);
    bus(RD, 9'h1FF, 16'h0000);
    chk("sat.hold", err_count, 8'hFF);
    bus(ID, 9'h000, 16'h0000);
    chk("sat.pulse_end", bus_err, 1'b0);

    // Asynchronous reset, then reset in the middle of a load
    reset = 1'b1;
    #1;
    chk("arst.cpu_reset", cpu_reset, 1'b1);
    chk("arst.led_out", led_out, 8'h00);
    chk("arst.err_count", err_count, 8'h00);
    chk("arst.read_data", read_data, 16'h0000);
    chk("arst0.cpu_reset", cpu_reset0, 1'b0);
    step();
    reset = 1'b0;
    ld_valid = 1'b1; ld_addr = 8'h05; ld_data = 16'hCAFE;
    step();
    ld_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst.cpu_reset", cpu_reset, 1'b1);
    chk("midrst.ld_ready", ld_ready, 1'b1);
    step();
    reset = 1'b0;
    step();
    chk("midrst.still_load", ld_ready, 1'b1);
    chk("midrst0.cpu_reset", cpu_reset0, 1'b0);
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    step();
    chk("midrst.run", cpu_reset, 1'b0);
    bus(RD, 9'h005, 16'h0000);
    chk("midrst.ram05", read_data, 16'hCAFE);
    bus(RD, 9'h03F, 16'h0000);
    chk("midrst.ram3f", read_data, 16'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
